// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, opcodes and state encoding for the memory stage
package mem_stage_pkg;

   localparam int REG_LENGTH   = 32;
   localparam int REG_ADDR_LEN = 5;
   localparam int OP_LENGTH    = 6;

   localparam logic [OP_LENGTH-1:0] OP_LW = 6'b100011;
   localparam logic [OP_LENGTH-1:0] OP_SW = 6'b101011;

   typedef enum logic {
      MEM_IDLE   = 1'b0,
      MEM_ACCESS = 1'b1
   } memState_t;

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: LW/SW over a req/ack bus, ALU pass-through, RegFile write-back
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = REG_LENGTH,
   parameter int RADDR_W = REG_ADDR_LEN,
   parameter int OP_W    = OP_LENGTH,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic [OP_W-1:0]    op,
   input  logic [DATA_W-1:0]  regcData,
   input  logic [RADDR_W-1:0] regcAddr,
   input  logic               regcWr,
   input  logic [DATA_W-1:0]  storeData,
   output logic               stall,
   output logic               memCe,
   output logic               memWe,
   output logic [DATA_W-1:0]  memAddr,
   output logic [DATA_W-1:0]  memWdata,
   input  logic [DATA_W-1:0]  memRdata,
   input  logic               memAck,
   output logic               we,
   output logic [RADDR_W-1:0] wAddr,
   output logic [DATA_W-1:0]  wData,
   output logic               err
);

   localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit             TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   memState_t          state, stateNext;
   logic               accStore;
   logic [RADDR_W-1:0] accRd;
   logic [CNT_W-1:0]   cnt;

   logic isLoad, isStore, aligned, accept, timedOut;

   assign isLoad   = (op == OP_W'(OP_LW));
   assign isStore  = (op == OP_W'(OP_SW));
   assign aligned  = (regcData[1:0] == 2'b00);
   assign accept   = (state == MEM_IDLE) && valid;
   // The last access cycle is counter value TIMEOUT-1; an ack on that edge still wins.
   assign timedOut = TO_EN && (cnt == CNT_LAST) && !memAck;

   assign stall = (state == MEM_ACCESS);
   assign memCe = stall;
   assign memWe = stall && accStore;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= MEM_IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         MEM_IDLE:   if (accept && (isLoad || isStore) && aligned) stateNext = MEM_ACCESS;
         MEM_ACCESS: if (memAck || timedOut) stateNext = MEM_IDLE;
         default:    stateNext = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         accStore <= 1'b0;
         accRd    <= '0;
         cnt      <= '0;
         memAddr  <= '0;
         memWdata <= '0;
         we       <= 1'b0;
         wAddr    <= '0;
         wData    <= '0;
         err      <= 1'b0;
      end else begin
         we  <= 1'b0;
         err <= 1'b0;
         if (state == MEM_IDLE) begin
            if (accept) begin
               if (isLoad || isStore) begin
                  if (aligned) begin
                     accStore <= isStore;
                     accRd    <= regcAddr;
                     memAddr  <= {regcData[DATA_W-1:2], 2'b00};
                     memWdata <= storeData;
                     cnt      <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end else begin
                  we    <= regcWr && (regcAddr != '0);
                  wAddr <= regcAddr;
                  wData <= regcData;
               end
            end
         end else if (memAck) begin
            if (!accStore) begin
               we    <= (accRd != '0);
               wAddr <= accRd;
               wData <= memRdata;
            end
         end else if (timedOut) begin
            err <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with a write-back scoreboard
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [5:0]  op;
   logic [31:0] regcData;
   logic [4:0]  regcAddr;
   logic        regcWr;
   logic [31:0] storeData;
   logic        stall, memCe, memWe;
   logic [31:0] memAddr, memWdata, memRdata;
   logic        memAck;
   logic        we;
   logic [4:0]  wAddr;
   logic [31:0] wData;
   logic        err;

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wb_t;

   wb_t sbQ[$];
   int  testsRun = 0;
   int  failCount = 0;

   mem_stage #(.DATA_W(32), .RADDR_W(5), .OP_W(6), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .valid(valid), .op(op), .regcData(regcData),
      .regcAddr(regcAddr), .regcWr(regcWr), .storeData(storeData),
      .stall(stall), .memCe(memCe), .memWe(memWe), .memAddr(memAddr),
      .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck),
      .we(we), .wAddr(wAddr), .wData(wData), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic monitorWb();
      wb_t e;
      if (we === 1'b1) begin
         if (sbQ.size() == 0) begin
            check("wb_unexpected", 32'(we), 32'd0);
         end else begin
            e = sbQ.pop_front();
            check("wb_addr", 32'(wAddr), 32'(e.a));
            check("wb_data", wData, e.d);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      monitorWb();
   endtask

   task automatic present(input logic v, input logic [5:0] o, input logic [31:0] d,
                          input logic [4:0] a, input logic [31:0] sd);
      valid     = v;
      op        = o;
      regcData  = d;
      regcAddr  = a;
      regcWr    = 1'b1;
      storeData = sd;
   endtask

   initial begin
      rst = 1'b0; memAck = 1'b0; memRdata = '0;
      present(1'b0, OP_ADD, 32'd0, 5'd0, 32'd0);
      tick();
      tick();
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_memCe", 32'(memCe), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_wData", wData, 32'd0);
      check("rst_memAddr", memAddr, 32'd0);
      rst = 1'b1;
      tick();

      // ALU pass-through, back to back, including a write to r0
      present(1'b1, OP_ADD, 32'h12345678, 5'd3, 32'd0);
      sbQ.push_back('{a: 5'd3, d: 32'h12345678});
      tick();
      check("pt_stall", 32'(stall), 32'd0);
      check("pt_we", 32'(we), 32'd1);
      present(1'b1, OP_ADD, 32'h55AA55AA, 5'd0, 32'd0);
      tick();
      check("pt_r0_we", 32'(we), 32'd0);
      present(1'b1, OP_ADD, 32'h00000077, 5'd7, 32'd0);
      sbQ.push_back('{a: 5'd7, d: 32'h00000077});
      tick();
      check("pt_sb_empty", 32'(sbQ.size()), 32'd0);

      // LW acked after two access cycles; the following ADD waits then issues
      present(1'b1, OP_LW, 32'h00000100, 5'd5, 32'd0);
      tick();
      present(1'b1, OP_ADD, 32'h00000099, 5'd9, 32'd0);
      check("lw_stall1", 32'(stall), 32'd1);
      check("lw_memCe", 32'(memCe), 32'd1);
      check("lw_memWe", 32'(memWe), 32'd0);
      check("lw_memAddr", memAddr, 32'h00000100);
      check("lw_we_acc", 32'(we), 32'd0);
      tick();
      check("lw_stall2", 32'(stall), 32'd1);
      check("lw_memAddr2", memAddr, 32'h00000100);
      memAck = 1'b1; memRdata = 32'hDEADBEEF;
      sbQ.push_back('{a: 5'd5, d: 32'hDEADBEEF});
      tick();
      memAck = 1'b0; memRdata = '0;
      check("lw_done_stall", 32'(stall), 32'd0);
      check("lw_done_memCe", 32'(memCe), 32'd0);
      sbQ.push_back('{a: 5'd9, d: 32'h00000099});
      tick();
      check("lw_next_sb", 32'(sbQ.size()), 32'd0);

      // SW acked in its first access cycle
      present(1'b1, OP_SW, 32'h00000204, 5'd2, 32'hCAFEF00D);
      tick();
      present(1'b0, OP_ADD, 32'd0, 5'd0, 32'd0);
      check("sw_stall", 32'(stall), 32'd1);
      check("sw_memCe", 32'(memCe), 32'd1);
      check("sw_memWe", 32'(memWe), 32'd1);
      check("sw_memAddr", memAddr, 32'h00000204);
      check("sw_memWdata", memWdata, 32'hCAFEF00D);
      memAck = 1'b1;
      tick();
      check("sw_we", 32'(we), 32'd0);
      check("sw_stall_done", 32'(stall), 32'd0);
      check("sw_memCe_done", 32'(memCe), 32'd0);
      tick();
      check("idle_ack_stall", 32'(stall), 32'd0);
      check("idle_ack_we", 32'(we), 32'd0);
      memAck = 1'b0;

      // Misaligned LW
      present(1'b1, OP_LW, 32'h00000102, 5'd6, 32'd0);
      tick();
      present(1'b0, OP_ADD, 32'd0, 5'd0, 32'd0);
      check("mis_err", 32'(err), 32'd1);
      check("mis_memCe", 32'(memCe), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      check("mis_we", 32'(we), 32'd0);
      tick();
      check("mis_err_pulse", 32'(err), 32'd0);
      check("mis_memCe2", 32'(memCe), 32'd0);

      // Timeout: four access cycles with no ack
      present(1'b1, OP_LW, 32'h00000300, 5'd8, 32'd0);
      tick();
      present(1'b0, OP_ADD, 32'd0, 5'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_stall%0d", i), 32'(stall), 32'd1);
         check($sformatf("to_noerr%0d", i), 32'(err), 32'd0);
         tick();
      end
      check("to_stall_end", 32'(stall), 32'd0);
      check("to_memCe_end", 32'(memCe), 32'd0);
      check("to_err", 32'(err), 32'd1);
      check("to_we", 32'(we), 32'd0);
      tick();
      check("to_err_pulse", 32'(err), 32'd0);

      // Ack on the fourth access cycle beats the timeout
      present(1'b1, OP_LW, 32'h00000400, 5'd10, 32'd0);
      tick();
      present(1'b0, OP_ADD, 32'd0, 5'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("ack4_stall%0d", i), 32'(stall), 32'd1);
         tick();
      end
      check("ack4_stall3", 32'(stall), 32'd1);
      memAck = 1'b1; memRdata = 32'h0BADF00D;
      sbQ.push_back('{a: 5'd10, d: 32'h0BADF00D});
      tick();
      memAck = 1'b0; memRdata = '0;
      check("ack4_err", 32'(err), 32'd0);
      check("ack4_stall_done", 32'(stall), 32'd0);
      check("ack4_sb", 32'(sbQ.size()), 32'd0);

      // Asynchronous reset in the middle of an access
      present(1'b1, OP_LW, 32'h00000500, 5'd11, 32'd0);
      tick();
      present(1'b0, OP_ADD, 32'd0, 5'd0, 32'd0);
      check("ar_memCe_before", 32'(memCe), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("ar_memCe", 32'(memCe), 32'd0);
      check("ar_stall", 32'(stall), 32'd0);
      check("ar_we", 32'(we), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("ar_idle_stall", 32'(stall), 32'd0);
      check("ar_idle_memCe", 32'(memCe), 32'd0);
      check("final_sb_empty", 32'(sbQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
